// File: rtl/pri_arb_pkg.sv
// ============================================================================
// Module      : pri_arb_pkg
// Description : Shared constants, state encoding and the 8-bit encoder helper
//               for the 32-input priority / round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pri_arb_pkg;

    localparam int N_REQ  = 32;
    localparam int ID_W   = 5;
    localparam int HOLD_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Highest set bit of an 8-bit vector; returns 0 when the vector is empty.
    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (v[k]) idx = 3'(k);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pri_find32.sv
// ============================================================================
// Module      : pri_find32
// Description : Highest-active-index finder for a 32-bit active-high vector,
//               built from four cascaded 8-bit priority encoder stages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_find32
    import pri_arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [ID_W-1:0]  idx_o,
    output logic             found_o
);

    // Chain runs from the low byte upward so a higher stage always overrides.
    logic [4:0]            chain_found;
    logic [ID_W-1:0]       chain_idx [5];

    assign chain_found[0] = 1'b0;
    assign chain_idx[0]   = '0;

    for (genvar s = 0; s < 4; s++) begin : g_stage
        logic [7:0] w_byte;
        logic       w_hit;
        assign w_byte = vec_i[8*s +: 8];
        assign w_hit  = |w_byte;
        assign chain_found[s+1] = w_hit | chain_found[s];
        assign chain_idx[s+1]   = w_hit ? {2'(s), enc8(w_byte)} : chain_idx[s];
    end

    assign idx_o   = chain_idx[4];
    assign found_o = chain_found[4];

endmodule

`default_nettype wire

// File: rtl/pri_arbiter_32.sv
// ============================================================================
// Module      : pri_arbiter_32
// Description : 32-input arbiter with active-low requests, fixed-priority or
//               round-robin selection, registered one-hot grant and hold limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pri_arbiter_32
    import pri_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] i,
    input  logic             en,
    input  logic             rr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  out,
    output logic             gv,
    output logic             gs,
    output logic             eo
);

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]     out_q, out_d;
    logic                gv_q, gv_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;

    logic [N_REQ-1:0]    w_req;
    logic [N_REQ-1:0]    w_below_mask;
    logic [ID_W-1:0]     w_idx_full, w_idx_below, w_winner;
    logic                w_found_full, w_found_below;
    logic                w_hold_hit;
    logic                w_release;

    assign w_req        = ~i;
    // Bits strictly below ptr; ptr=0 gives an empty mask.
    assign w_below_mask = (N_REQ'(1) << ptr_q) - N_REQ'(1);

    pri_find32 u_find_full (
        .vec_i   (w_req),
        .idx_o   (w_idx_full),
        .found_o (w_found_full)
    );

    pri_find32 u_find_below (
        .vec_i   (w_req & w_below_mask),
        .idx_o   (w_idx_below),
        .found_o (w_found_below)
    );

    assign w_winner   = (rr && w_found_below) ? w_idx_below : w_idx_full;
    // Count after this cycle's increment reaching the limit ends the grant.
    assign w_hold_hit = (MAX_HOLD != 0) &&
                        (({1'b0, hold_q} + 9'd1) >= 9'(MAX_HOLD));
    assign w_release  = i[out_q] | en | w_hold_hit;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        out_d   = out_q;
        gv_d    = gv_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (!en && w_found_full) begin
                    state_d = GRANT;
                    gnt_d   = N_REQ'(1) << w_winner;
                    out_d   = w_winner;
                    gv_d    = 1'b1;
                    ptr_d   = w_winner;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    gv_d    = 1'b0;
                end else if (hold_q != {HOLD_W{1'b1}}) begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                gv_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            out_q   <= '0;
            gv_q    <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            out_q   <= out_d;
            gv_q    <= gv_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt = gnt_q;
    assign out = out_q;
    assign gv  = gv_q;
    assign gs  = ~(~en & ~(&i));
    assign eo  = ~(~en & (&i));

endmodule

`default_nettype wire

// File: tb/tb_pri_arbiter_32.sv
// ============================================================================
// Module      : tb_pri_arbiter_32
// Description : Directed self-checking bench for pri_arbiter_32 (default hold
//               limit instance plus a MAX_HOLD=4 instance).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pri_arbiter_32;

    logic        clk;
    logic        rst;
    logic [31:0] req_n;
    logic [31:0] req_h_n;
    logic        en;
    logic        rr;

    logic [31:0] gnt, gnt_h;
    logic [4:0]  out, out_h;
    logic        gv, gv_h;
    logic        gs, gs_h;
    logic        eo, eo_h;

    int checks = 0;
    int errors = 0;

    pri_arbiter_32 u_dut (
        .clk (clk),
        .rst (rst),
        .i   (req_n),
        .en  (en),
        .rr  (rr),
        .gnt (gnt),
        .out (out),
        .gv  (gv),
        .gs  (gs),
        .eo  (eo)
    );

    pri_arbiter_32 #(.MAX_HOLD(4)) u_h4 (
        .clk (clk),
        .rst (rst),
        .i   (req_h_n),
        .en  (en),
        .rr  (rr),
        .gnt (gnt_h),
        .out (out_h),
        .gv  (gv_h),
        .gs  (gs_h),
        .eo  (eo_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        int          owners [4];
        logic [31:0] one_hot;
        logic        hold_gv [10];

        owners  = '{20, 9, 5, 20};
        hold_gv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; req_n = '1; req_h_n = '1; en = 1'b0; rr = 1'b0;
        tick(); tick();
        check("rst_gnt", gnt, 32'h0);
        check("rst_gv",  32'(gv), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_ptr", 32'(u_dut.ptr_q), 32'h0);
        check("rst_eo_idle", 32'(eo), 32'h0);
        rst = 1'b0;

        // Fixed priority among 3, 17, 30
        req_n = ~((32'd1 << 3) | (32'd1 << 17) | (32'd1 << 30));
        #1 check("fix_gs", 32'(gs), 32'h0);
        tick();
        check("fix_gnt30", gnt, 32'h4000_0000);
        check("fix_out30", 32'(out), 32'd30);
        check("fix_gv",    32'(gv), 32'h1);
        req_n[30] = 1'b1;
        tick();
        check("fix_rel_gv",  32'(gv), 32'h0);
        check("fix_rel_out", 32'(out), 32'd30);
        tick();
        check("fix_gnt17", gnt, 32'h0002_0000);
        check("fix_out17", 32'(out), 32'd17);

        // All requests idle: ptr must stay at the last winner
        req_n = '1;
        tick(); tick(); tick();
        check("idle_gv",  32'(gv), 32'h0);
        check("idle_ptr", 32'(u_dut.ptr_q), 32'd17);

        // Round robin among 5, 9, 20 from ptr=0
        rst = 1'b1; tick(); rst = 1'b0;
        rr = 1'b1;
        req_n = ~((32'd1 << 5) | (32'd1 << 9) | (32'd1 << 20));
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rr_out_c1", 32'(out), 32'(owners[n]));
            check("rr_gv_c1",  32'(gv), 32'h1);
            tick();
            check("rr_out_c2", 32'(out), 32'(owners[n]));
            req_n[owners[n]] = 1'b1;
            tick();
            check("rr_rel_gv", 32'(gv), 32'h0);
            req_n[owners[n]] = 1'b0;
        end
        req_n = '1;
        tick(); tick();

        // Hold limit of 4 with a single steady requester
        req_h_n = ~(32'd1 << 7);
        for (int n = 0; n < 10; n++) begin
            tick();
            check("hold_gv", 32'(gv_h), 32'(hold_gv[n]));
            if (hold_gv[n]) check("hold_out", 32'(out_h), 32'd7);
        end
        req_h_n = '1;
        tick(); tick();

        // Enable dropped mid-grant
        rr = 1'b0;
        req_n = ~(32'd1 << 12);
        tick();
        check("en_gv_on", 32'(gv), 32'h1);
        en = 1'b1;
        #1;
        check("en_dis_gs", 32'(gs), 32'h1);
        check("en_dis_eo", 32'(eo), 32'h1);
        tick();
        check("en_dis_gv", 32'(gv), 32'h0);
        tick();
        check("en_dis_nogrant", 32'(gv), 32'h0);
        req_n = '1; en = 1'b0;
        #1;
        check("en_eo_low",  32'(eo), 32'h0);
        check("en_gs_high", 32'(gs), 32'h1);
        tick();
        check("en_idle_gv", 32'(gv), 32'h0);

        // Reset in the middle of a grant to 12
        req_n = ~(32'd1 << 12);
        tick();
        check("rmid_out12", 32'(out), 32'd12);
        rst = 1'b1;
        tick();
        check("rmid_gnt", gnt, 32'h0);
        check("rmid_gv",  32'(gv), 32'h0);
        check("rmid_out", 32'(out), 32'h0);
        check("rmid_ptr", 32'(u_dut.ptr_q), 32'h0);
        rst = 1'b0;
        tick();
        check("rmid_regnt", gnt, 32'h0000_1000);

        // Owner 31 releases at the same edge that request 0 appears
        req_n = ~(32'd1 << 31);
        tick();
        check("sim_gap1", 32'(gv), 32'h0);
        tick();
        check("sim_out31", 32'(out), 32'd31);
        req_n = ~32'd1;
        tick();
        check("sim_idle", 32'(gv), 32'h0);
        tick();
        one_hot = 32'd1;
        check("sim_gnt0", gnt, one_hot);
        check("sim_out0", 32'(out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

endmodule

`default_nettype wire
